// File: rtl/dtw_query_packer.sv
// dtw_query_packer
// Frames raw AXI-stream squiggle packets into fixed-length DTW queries for
// the src FIFO: one query-id header word followed by exactly SQG_SIZE sample
// words. Short packets are padded by repeating the last sample; long packets
// are truncated and their surplus beats drained without writes.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   en                  start enable, sampled only while idle
//   s_axis_t*           raw sample stream (tdata/tvalid/tlast in, tready out)
//   src_fifo_*          FIFO write side (wren/data out, full in)
//   busy, dbg_*         status: busy, state encoding, query/pad/drop counters
module dtw_query_packer #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned AXIS_WIDTH = 32,
  parameter int unsigned SQG_SIZE   = 250,
  parameter logic [31:0] QID_INIT   = 32'd0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [AXIS_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  src_fifo_wren,
  input  logic                  src_fifo_full,
  output logic [31:0]           src_fifo_data,
  output logic                  busy,
  output logic [2:0]            dbg_state,
  output logic [31:0]           dbg_nquery,
  output logic [31:0]           dbg_npad,
  output logic [31:0]           dbg_ndrop
);

  localparam int unsigned CW = $clog2(SQG_SIZE + 1);
  // Count value at which the next written sample completes the query.
  localparam logic [CW-1:0] LP_LAST = CW'(SQG_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    SAMP  = 3'd2,
    PAD   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t         r_state;
  logic [31:0]    r_qid;
  logic [CW-1:0]  r_cnt;
  logic [31:0]    r_last;
  logic [31:0]    r_nquery;
  logic [31:0]    r_npad;
  logic [31:0]    r_ndrop;

  logic           w_tready;
  logic           w_wren;
  logic [31:0]    w_data;
  logic [31:0]    w_samp;
  logic           w_accept;
  logic           w_done;
  logic           w_unused;

  assign w_unused = ^s_axis_tdata;

  always_comb begin
    w_tready = 1'b0;
    w_wren   = 1'b0;
    w_data   = '0;
    w_done   = 1'b0;
    w_samp   = '0;
    w_samp[WIDTH-1:0] = s_axis_tdata[WIDTH-1:0];
    case (r_state)
      HDR: begin
        w_wren = !src_fifo_full;
        w_data = r_qid;
      end
      SAMP: begin
        w_tready = !src_fifo_full;
        w_wren   = s_axis_tvalid && !src_fifo_full;
        w_data   = w_samp;
        w_done   = w_wren && s_axis_tlast && (r_cnt == LP_LAST);
      end
      PAD: begin
        w_wren = !src_fifo_full;
        w_data = r_last;
        w_done = w_wren && (r_cnt == LP_LAST);
      end
      DRAIN: begin
        // Surplus beats are swallowed even while the FIFO is full.
        w_tready = 1'b1;
        w_done   = s_axis_tvalid && s_axis_tlast;
      end
      default: ;
    endcase
  end

  assign w_accept = s_axis_tvalid && w_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_qid    <= QID_INIT;
      r_cnt    <= '0;
      r_last   <= '0;
      r_nquery <= '0;
      r_npad   <= '0;
      r_ndrop  <= '0;
    end else begin
      case (r_state)
        IDLE: if (en && s_axis_tvalid) r_state <= HDR;
        HDR: begin
          if (!src_fifo_full) begin
            r_cnt   <= '0;
            r_state <= SAMP;
          end
        end
        SAMP: begin
          if (w_accept) begin
            r_last <= w_samp;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == LP_LAST) begin
              if (!s_axis_tlast) r_state <= DRAIN;
            end else if (s_axis_tlast) begin
              r_state <= PAD;
            end
          end
        end
        PAD: begin
          if (!src_fifo_full) begin
            r_cnt  <= r_cnt + 1'b1;
            r_npad <= r_npad + 32'd1;
          end
        end
        DRAIN: if (s_axis_tvalid) r_ndrop <= r_ndrop + 32'd1;
        default: r_state <= IDLE;
      endcase
      // Completion overrides the per-state next-state choice above.
      if (w_done) begin
        r_qid    <= r_qid + 32'd1;
        r_nquery <= r_nquery + 32'd1;
        r_state  <= IDLE;
      end
    end
  end

  assign s_axis_tready = w_tready;
  assign src_fifo_wren = w_wren;
  assign src_fifo_data = w_data;
  assign busy          = (r_state != IDLE);
  assign dbg_state     = r_state;
  assign dbg_nquery    = r_nquery;
  assign dbg_npad      = r_npad;
  assign dbg_ndrop     = r_ndrop;

endmodule

// File: tb/tb_dtw_query_packer.sv
module tb_dtw_query_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_a = 1'b0;
  logic        en_b = 1'b0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        full = 1'b0;
  logic        sel = 1'b0;

  logic        tready_a, wren_a, busy_a;
  logic [31:0] data_a, nq_a, npad_a, ndrop_a;
  logic [2:0]  st_a;
  logic        tready_b, wren_b, busy_b;
  logic [31:0] data_b, nq_b, npad_b, ndrop_b;
  logic [2:0]  st_b;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] ex[$];
  int          total = 0;
  int          bad = 0;
  int          viol = 0;

  always #5 clk = ~clk;

  dtw_query_packer #(.WIDTH(16), .AXIS_WIDTH(32), .SQG_SIZE(4), .QID_INIT(32'd0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
    .s_axis_tready(tready_a), .src_fifo_wren(wren_a), .src_fifo_full(full),
    .src_fifo_data(data_a), .busy(busy_a), .dbg_state(st_a),
    .dbg_nquery(nq_a), .dbg_npad(npad_a), .dbg_ndrop(ndrop_a));

  dtw_query_packer #(.WIDTH(16), .AXIS_WIDTH(32), .SQG_SIZE(1), .QID_INIT(32'hFFFF_FFFF)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
    .s_axis_tready(tready_b), .src_fifo_wren(wren_b), .src_fifo_full(full),
    .src_fifo_data(data_b), .busy(busy_b), .dbg_state(st_b),
    .dbg_nquery(nq_b), .dbg_npad(npad_b), .dbg_ndrop(ndrop_b));

  always @(posedge clk) begin
    if (rst_n && wren_a) begin
      qa.push_back(data_a);
      if (full) viol++;
    end
    if (rst_n && wren_b) begin
      qb.push_back(data_b);
      if (full) viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares captured FIFO words of the selected instance against ex, then clears it.
  task automatic chkq(input string tag, input bit which);
    logic [31:0] got[$];
    got = which ? qb : qa;
    chk({tag, "_count"}, 32'(got.size()), 32'(ex.size()));
    for (int i = 0; i < ex.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), (i < got.size()) ? got[i] : 32'hDEAD_BEEF, ex[i]);
    if (which) qb.delete(); else qa.delete();
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic beat(input logic [31:0] d, input bit last);
    int n;
    logic rdy;
    tdata = d; tvalid = 1'b1; tlast = last;
    #1;
    n = 0;
    rdy = sel ? tready_b : tready_a;
    while (!rdy && n < 50) begin
      @(negedge clk); #1;
      n++;
      rdy = sel ? tready_b : tready_a;
    end
    total++;
    assert (n < 50) else begin
      bad++;
      $error("FAIL beat_timeout observed=%0d expected=<50", n);
    end
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1;
    // Reset values
    chk("rst_tready", {31'd0, tready_a}, 32'd0);
    chk("rst_wren",   {31'd0, wren_a}, 32'd0);
    chk("rst_data",   data_a, 32'd0);
    chk("rst_busy",   {31'd0, busy_a}, 32'd0);
    chk("rst_state",  {29'd0, st_a}, 32'd0);
    chk("rst_nquery", nq_a, 32'd0);
    chk("rst_npad",   npad_a, 32'd0);
    chk("rst_ndrop",  ndrop_a, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // SQG_SIZE=1 instance, qid wraps from 0xFFFFFFFF to 0
    sel = 1'b1; en_b = 1'b1;
    beat(32'h7, 1'b1);
    idle(2);
    beat(32'h9, 1'b1);
    idle(3);
    en_b = 1'b0;
    ex = '{32'hFFFF_FFFF, 32'h7, 32'h0, 32'h9};
    chkq("wrap_sqg1", 1'b1);
    chk("b_npad", npad_b, 32'd0);
    chk("b_ndrop", ndrop_b, 32'd0);
    chk("b_nquery", nq_b, 32'd2);

    // Exact-length packet
    sel = 1'b0; en_a = 1'b1;
    beat(32'h11, 1'b0); beat(32'h22, 1'b0); beat(32'h33, 1'b0); beat(32'h44, 1'b1);
    idle(3);
    ex = '{32'h0, 32'h11, 32'h22, 32'h33, 32'h44};
    chkq("exact", 1'b0);
    chk("exact_nquery", nq_a, 32'd1);
    chk("exact_state", {29'd0, st_a}, 32'd0);

    // Short packet is padded with its last sample
    beat(32'hA, 1'b0); beat(32'hB, 1'b1);
    idle(6);
    ex = '{32'h1, 32'hA, 32'hB, 32'hB, 32'hB};
    chkq("pad", 1'b0);
    chk("pad_npad", npad_a, 32'd2);

    // Long packet is truncated, surplus drained; upper tdata bits ignored
    beat(32'hFFFF_0001, 1'b0); beat(32'h2, 1'b0); beat(32'h3, 1'b0);
    beat(32'h4, 1'b0); beat(32'h5, 1'b0); beat(32'h6, 1'b1);
    idle(3);
    ex = '{32'h2, 32'h1, 32'h2, 32'h3, 32'h4};
    chkq("drop", 1'b0);
    chk("drop_ndrop", ndrop_a, 32'd2);
    chk("drop_nquery", nq_a, 32'd3);

    // FIFO full for 3 cycles right after the header
    tdata = 32'h1; tvalid = 1'b1; tlast = 1'b0;
    @(negedge clk); @(negedge clk);
    full = 1'b1; #1;
    chk("stall_busy", {31'd0, busy_a}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      chk($sformatf("stall_tready%0d", i), {31'd0, tready_a}, 32'd0);
      chk($sformatf("stall_wren%0d", i), {31'd0, wren_a}, 32'd0);
    end
    @(negedge clk);
    full = 1'b0;
    beat(32'h1, 1'b0); beat(32'h2, 1'b0); beat(32'h3, 1'b0); beat(32'h4, 1'b1);
    idle(3);
    ex = '{32'h3, 32'h1, 32'h2, 32'h3, 32'h4};
    chkq("stall", 1'b0);

    // Reset in mid-packet
    beat(32'h1, 1'b0); beat(32'h2, 1'b0);
    rst_n = 1'b0; #1;
    chk("mid_rst_tready", {31'd0, tready_a}, 32'd0);
    chk("mid_rst_wren",   {31'd0, wren_a}, 32'd0);
    chk("mid_rst_data",   data_a, 32'd0);
    chk("mid_rst_busy",   {31'd0, busy_a}, 32'd0);
    chk("mid_rst_state",  {29'd0, st_a}, 32'd0);
    chk("mid_rst_nquery", nq_a, 32'd0);
    chk("mid_rst_npad",   npad_a, 32'd0);
    chk("mid_rst_ndrop",  ndrop_a, 32'd0);
    ex = '{32'h4, 32'h1, 32'h2};
    chkq("partial", 1'b0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Three back-to-back packets after reset: headers restart at QID_INIT
    for (int p = 0; p < 3; p++) begin
      beat(32'h10 + p, 1'b0); beat(32'h20, 1'b0); beat(32'h30, 1'b0); beat(32'h40, 1'b1);
    end
    idle(3);
    ex = '{32'h0, 32'h10, 32'h20, 32'h30, 32'h40,
           32'h1, 32'h11, 32'h20, 32'h30, 32'h40,
           32'h2, 32'h12, 32'h20, 32'h30, 32'h40};
    chkq("b2b", 1'b0);
    chk("b2b_nquery", nq_a, 32'd3);
    chk("wren_vs_full", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dtw_query_packer.md
Name: dtw_query_packer

Overview:
Producer side of the DTW source FIFO. Accepts raw squiggle packets on an AXI-stream slave and writes each one into the src FIFO as one framed query: a query-id header word followed by exactly SQG_SIZE sample words. Short packets are padded and long packets are truncated, so the DTW core always sees fixed-length queries. It sits between the DMA/AXIS input and the src FIFO that feeds the DTW core.

Parameters:
WIDTH, 16, sample width; the low WIDTH bits of each beat are zero-extended to 32 bits.
AXIS_WIDTH, 32, s_axis_tdata width; must be at least WIDTH.
SQG_SIZE, 250, samples per emitted query; must be at least 1.
QID_INIT, 0, query id assigned to the first packet after reset.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
en  in  1  enable; sampled only in IDLE.
s_axis_tdata  in  AXIS_WIDTH  raw sample beat.
s_axis_tvalid  in  1  beat valid.
s_axis_tlast  in  1  last beat of packet.
s_axis_tready  out  1  beat accepted when tvalid & tready.
src_fifo_wren  out  1  src FIFO write enable.
src_fifo_full  in  1  src FIFO full.
src_fifo_data  out  32  src FIFO write data.
busy  out  1  high in any state except IDLE.
dbg_state  out  3  current state encoding.
dbg_nquery  out  32  number of queries completed.
dbg_npad  out  32  total pad words written.
dbg_ndrop  out  32  total beats discarded.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; qid = QID_INIT; sample count, last-sample register and all dbg counters = 0. Outputs during reset: s_axis_tready = 0, src_fifo_wren = 0, src_fifo_data = 0, busy = 0. A reset in mid-packet abandons the partial query; nothing is resumed.
- Output timing: tready, wren and data are combinational from the state registers and src_fifo_full. A FIFO write happens only in a cycle where src_fifo_full = 0. At most one write per cycle.
- State encoding: IDLE = 0, HDR = 1, SAMP = 2, PAD = 3, DRAIN = 4.
- IDLE: tready = 0, wren = 0. Go to HDR when en & s_axis_tvalid. The beat is not consumed here.
- HDR: wren = !full and data = qid. On a write, clear the sample count and go to SAMP. Stay in HDR while full.
- SAMP: tready = !full. On an accepted beat:
  - wren = 1 and data = {zeros, tdata[WIDTH-1:0]}.
  - The sample is stored in the last-sample register and the count increments.
  - If count+1 == SQG_SIZE and tlast: query done.
  - If count+1 == SQG_SIZE and !tlast: go to DRAIN.
  - If count+1 < SQG_SIZE and tlast: go to PAD.
  - Otherwise stay in SAMP.
- PAD: wren = !full, data = last-sample register (last sample repeated). Each write increments count and dbg_npad. After the write that makes count == SQG_SIZE, the query is done.
- DRAIN: tready = 1 regardless of full, wren = 0. Each accepted beat increments dbg_ndrop. An accepted tlast means the query is done.
- Query done: qid increments, with 32-bit wrap from 0xFFFFFFFF to 0. dbg_nquery increments. Next state is IDLE, so there is at least one idle cycle between queries.
- en is ignored outside IDLE. Deasserting en mid-packet lets the current packet complete.
- The sample count is wide enough for SQG_SIZE; clog2(SQG_SIZE+1) bits are sufficient.
- Full asserted mid-query: the current word is held with no write and no accept. The word and counters are unchanged until full drops. No word is lost or duplicated.
- tvalid dropping in SAMP: the block simply waits. No pad is inserted until tlast is seen.
- Words written per query: always exactly 1 + SQG_SIZE.

Test Plan:
- SQG_SIZE=4, packet 0x11,0x22,0x33,0x44 with tlast on 0x44, src_fifo_full=0 → FIFO receives 0,0x11,0x22,0x33,0x44; dbg_nquery=1; state returns to IDLE; next query id is 1.
- SQG_SIZE=4, packet 0xA,0xB with tlast on 0xB → FIFO receives 0,0xA,0xB,0xB,0xB; dbg_npad=2.
- SQG_SIZE=4, 6-beat packet 1..6 with tlast on 6 → FIFO receives 0,1,2,3,4; beats 5 and 6 are accepted with no write; dbg_ndrop=2; FIFO write count is 5.
- SQG_SIZE=4, packet 1..4, hold src_fifo_full=1 for 3 cycles after the header → tready=0 and wren=0 while full; FIFO contents are identical to the no-stall case; wren never coincides with full.
- Three back-to-back packets → headers 0,1,2. With QID_INIT=0xFFFFFFFF and two packets → headers 0xFFFFFFFF then 0.
- rst_n pulsed low after 2 samples written → all outputs are 0 immediately; the next packet gets header QID_INIT; the SQG_SIZE=1 packet 0x7 with tlast writes 0,0x7 with no pad or drop.
